// File: rtl/spi_arbiter.sv
// ---------------------------------------------------------------------------
// spi_arbiter
//
// Shares one SPI master among three requesters. Picks a winner round-robin,
// presents that requester's clock polarity/phase and grant, issues a single
// start strobe to the master, then follows the master's chip select to find
// the end of the transaction. After completion it enforces an idle gap
// before the next grant. All outputs are registered.
//
// Optional feature (compile-time macro SPI_ARB_TIMEOUT_EN):
//   A watchdog covers WAIT_LOW and BUSY. If it expires, timeout_err pulses
//   for one cycle, no done is given, and the arbiter moves to GAP.
//   Without the macro there is no watchdog and timeout_err is tied low.
//
// Parameters
//   GAP      idle cycles between the end of a transaction and the next grant (1..15)
//   TIMEOUT  watchdog limit in clk cycles (1..65535), SPI_ARB_TIMEOUT_EN only
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   req[2:0]         per-requester request level, held until matching done
//   cfg_ckp[2:0]     per-requester SPI clock polarity
//   cfg_cph[2:0]     per-requester SPI clock phase
//   CS               chip select from the SPI master, active low
//   transaction_stb  one-cycle start strobe to the SPI master
//   CKP, CPH         polarity/phase of the current owner
//   gnt[2:0]         one-hot grant
//   done[2:0]        one-cycle completion pulse to the owner
//   timeout_err      one-cycle watchdog pulse
// ---------------------------------------------------------------------------
module spi_arbiter #(
    parameter int GAP     = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] cfg_ckp,
    input  logic [2:0] cfg_cph,
    input  logic       CS,
    output logic       transaction_stb,
    output logic       CKP,
    output logic       CPH,
    output logic [2:0] gnt,
    output logic [2:0] done,
    output logic       timeout_err
);

    if (GAP < 1 || GAP > 15) begin : g_bad_gap
        $error("spi_arbiter: GAP must be in 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("spi_arbiter: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT_LOW,
        S_BUSY,
        S_GAP
    } state_t;

    state_t     state, state_d;
    logic [1:0] last, last_d;        // index of the most recently granted requester
    logic [1:0] winner;
    logic [3:0] gap_cnt, gap_d;
    logic [2:0] gnt_d, done_d;
    logic       stb_d, ckp_d, cph_d;

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt, wd_d;
    logic        tmo_q, tmo_d;
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Round-robin pick: search starts just after the last served requester,
    // so the last one served has the lowest priority.
    always_comb begin
        int idx;
        winner = last;
        for (int k = 3; k >= 1; k--) begin
            idx = (int'(last) + k) % 3;
            if (req[idx]) begin
                winner = 2'(idx);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        last_d  = last;
        gap_d   = gap_cnt;
        gnt_d   = gnt;
        done_d  = 3'b000;
        stb_d   = 1'b0;
        ckp_d   = CKP;
        cph_d   = CPH;
`ifdef SPI_ARB_TIMEOUT_EN
        wd_d    = wd_cnt + 16'd1;
        tmo_d   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (|req) begin
                    last_d  = winner;
                    gnt_d   = 3'b001 << winner;
                    ckp_d   = cfg_ckp[winner];
                    cph_d   = cfg_cph[winner];
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                stb_d   = 1'b1;      // strobe is visible while in START
                state_d = S_START;
            end
            S_START: begin
                state_d = S_WAIT_LOW;
`ifdef SPI_ARB_TIMEOUT_EN
                wd_d    = 16'd0;
`endif
            end
            S_WAIT_LOW: begin
                if (!CS) begin
                    state_d = S_BUSY;
`ifdef SPI_ARB_TIMEOUT_EN
                    wd_d    = 16'd0;
                end else if (wd_cnt == 16'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    gnt_d   = 3'b000;
                    gap_d   = 4'd0;
                    state_d = S_GAP;
`endif
                end
            end
            S_BUSY: begin
                if (CS) begin
                    done_d  = gnt;
                    gnt_d   = 3'b000;
                    gap_d   = 4'd0;
                    state_d = S_GAP;
`ifdef SPI_ARB_TIMEOUT_EN
                end else if (wd_cnt == 16'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    gnt_d   = 3'b000;
                    gap_d   = 4'd0;
                    state_d = S_GAP;
`endif
                end
            end
            S_GAP: begin
                if (gap_cnt == 4'(GAP - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_cnt + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    // NOTE: state and output registers use non-blocking assignments so every
    // flop samples the values present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            last            <= 2'd2;     // requester 0 has top priority after reset
            gap_cnt         <= 4'd0;
            gnt             <= 3'b000;
            done            <= 3'b000;
            transaction_stb <= 1'b0;
            CKP             <= 1'b0;
            CPH             <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            wd_cnt          <= 16'd0;
            tmo_q           <= 1'b0;
`endif
        end else begin
            state           <= state_d;
            last            <= last_d;
            gap_cnt         <= gap_d;
            gnt             <= gnt_d;
            done            <= done_d;
            transaction_stb <= stb_d;
            CKP             <= ckp_d;
            CPH             <= cph_d;
`ifdef SPI_ARB_TIMEOUT_EN
            wd_cnt          <= wd_d;
            tmo_q           <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_arbiter
//
// Directed bench for spi_arbiter with hand-computed expectations: reset
// state, single transaction timing, round-robin contention and gap, fairness,
// early request drop, CS ignored while idle, reset during BUSY, and (with
// SPI_ARB_TIMEOUT_EN) the watchdog.
// ---------------------------------------------------------------------------
module tb_spi_arbiter;

    localparam int GAP     = 2;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [2:0] cfg_ckp;
    logic [2:0] cfg_cph;
    logic       CS;
    logic       transaction_stb;
    logic       CKP;
    logic       CPH;
    logic [2:0] gnt;
    logic [2:0] done;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;

    spi_arbiter #(.GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .cfg_ckp         (cfg_ckp),
        .cfg_cph         (cfg_cph),
        .CS              (CS),
        .transaction_stb (transaction_stb),
        .CKP             (CKP),
        .CPH             (CPH),
        .gnt             (gnt),
        .done            (done),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".gnt"},  32'(gnt), 32'h0);
        check({tag, ".done"}, 32'(done), 32'h0);
        check({tag, ".stb"},  32'(transaction_stb), 32'h0);
        check({tag, ".ckp"},  32'(CKP), 32'h0);
        check({tag, ".cph"},  32'(CPH), 32'h0);
        check({tag, ".tmo"},  32'(timeout_err), 32'h0);
    endtask

    // One full transaction: wait for grant, follow strobe, drive CS low for two
    // cycles (dropping 'drop' bits of req during BUSY), raise CS, check done.
    // idle returns how many sampled cycles gnt was low before the grant.
    task automatic do_txn(input string tag, input logic [2:0] exp_g,
                          input logic exp_ckp, input logic exp_cph,
                          input logic [2:0] drop, output int idle);
        idle = 0;
        while (gnt == 3'b000 && idle < 20) begin
            idle++;
            tick();
        end
        check({tag, ".gnt"},  32'(gnt), 32'(exp_g));
        check({tag, ".ckp"},  32'(CKP), 32'(exp_ckp));
        check({tag, ".cph"},  32'(CPH), 32'(exp_cph));
        check({tag, ".stb_setup"}, 32'(transaction_stb), 32'h0);
        tick();
        check({tag, ".stb_start"}, 32'(transaction_stb), 32'h1);
        tick();
        check({tag, ".stb_wait"}, 32'(transaction_stb), 32'h0);
        CS = 1'b0;
        tick();
        req = req & ~drop;
        tick();
        check({tag, ".busy_done"}, 32'(done), 32'h0);
        check({tag, ".busy_gnt"},  32'(gnt), 32'(exp_g));
        CS = 1'b1;
        tick();
        check({tag, ".done"},     32'(done), 32'(exp_g));
        check({tag, ".gnt_off"},  32'(gnt), 32'h0);
        check({tag, ".ckp_hold"}, 32'(CKP), 32'(exp_ckp));
    endtask

    initial begin
        int idle;
        int n;
        rst     = 1'b1;
        req     = 3'b000;
        cfg_ckp = 3'b000;
        cfg_cph = 3'b000;
        CS      = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // CS activity while idle must be ignored.
        CS = 1'b0;
        tick();
        tick();
        CS = 1'b1;
        tick();
        check_all_zero("cs_idle");

        // Single request: gnt/CKP/CPH at +1, strobe at +2, done after CS rises.
        req     = 3'b010;
        cfg_ckp = 3'b010;
        cfg_cph = 3'b000;
        tick();
        check("single.gnt_c1", 32'(gnt), 32'h2);
        do_txn("single", 3'b010, 1'b1, 1'b0, 3'b000, idle);
        check("single.latency", 32'(idle), 32'h0);
        req = 3'b000;
        tick();
        check("single.done_once", 32'(done), 32'h0);

        // Contention after reset: 001, 010, 100 with at least GAP idle cycles between.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cfg_ckp = 3'b000;
        cfg_cph = 3'b101;
        req     = 3'b111;
        do_txn("rr0", 3'b001, 1'b0, 1'b1, 3'b000, idle);
        do_txn("rr1", 3'b010, 1'b0, 1'b0, 3'b000, idle);
        check("rr1.gap", 32'(idle >= GAP), 32'h1);
        do_txn("rr2", 3'b100, 1'b0, 1'b1, 3'b000, idle);
        check("rr2.gap", 32'(idle >= GAP), 32'h1);

        // Fairness: after 100, requesters 0 and 2 compete -> 0 wins.
        req = 3'b101;
        do_txn("fair", 3'b001, 1'b0, 1'b1, 3'b000, idle);

        // Early drop: req[0] falls during BUSY; done still pulses.
        req = 3'b001;
        do_txn("drop", 3'b001, 1'b0, 1'b1, 3'b001, idle);
        check("drop.req_low", 32'(req), 32'h0);

        // Reset during BUSY: all outputs clear, no done, held req re-granted.
        cfg_ckp = 3'b100;
        cfg_cph = 3'b100;
        req     = 3'b100;
        n = 0;
        while (gnt == 3'b000 && n < 20) begin
            n++;
            tick();
        end
        check("rstbusy.gnt", 32'(gnt), 32'h4);
        tick();
        tick();
        CS = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        CS  = 1'b1;
        check_all_zero("rstbusy");
        tick();
        check("rstbusy.no_done", 32'(done), 32'h0);
        do_txn("regrant", 3'b100, 1'b1, 1'b1, 3'b000, idle);
        req = 3'b000;

`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog: CS stays high after the strobe.
        req = 3'b010;
        n = 0;
        while (transaction_stb == 1'b0 && n < 20) begin
            n++;
            tick();
        end
        check("tmo.stb", 32'(transaction_stb), 32'h1);
        n = 0;
        while (timeout_err == 1'b0 && n < 60) begin
            n++;
            tick();
            if (done != 3'b000) check("tmo.no_done", 32'(done), 32'h0);
        end
        // START cycle -> WAIT_LOW entry (1) + TIMEOUT cycles.
        check("tmo.latency", 32'(n), 32'(TIMEOUT + 1));
        check("tmo.gnt_off", 32'(gnt), 32'h0);
        req = 3'b000;
        tick();
        check("tmo.pulse_once", 32'(timeout_err), 32'h0);
        tick();
        tick();
        req = 3'b001;
        do_txn("tmo.after", 3'b001, 1'b0, 1'b0, 3'b000, idle);
        req = 3'b000;
`else
        check("tmo.tied", 32'(timeout_err), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
